// File: rtl/x83_seq_ctrl.sv
// rtl/x83_seq_ctrl.sv - sequential x*83 multiplier with one shared adder (X83_FULL_PROD_EN widens output)
module x83_seq_ctrl #(
    parameter int WIDTH = 8,
`ifdef X83_FULL_PROD_EN
    localparam int OW = WIDTH + 7
`else
    localparam int OW = WIDTH
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    data_out,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       step;
    logic [WIDTH-1:0] x_reg;
    logic [OW-1:0]    acc;
    logic [OW-1:0]    x_ext;
    logic [OW-1:0]    addend;
    logic [OW-1:0]    sum;

    assign x_ext = OW'(x_reg);

    // Pick the shifted term for the current step; 83 = 1 + 2 + 16 + 64
    always_comb begin
        addend = '0;
        case (step)
            2'd1:    addend = x_ext << 1;
            2'd2:    addend = x_ext << 4;
            2'd3:    addend = x_ext << 6;
            default: addend = '0;
        endcase
    end

    // The single shared adder, wrapping modulo 2^OW
    assign sum = acc + addend;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign data_out  = acc;

    // Sequencer: accept operand, add three shifted terms, hold result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 2'd0;
            x_reg <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= data_in;
                        acc   <= OW'(data_in);
                        step  <= 2'd1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc  <= sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x83_seq_ctrl.sv
// tb/tb_x83_seq_ctrl.sv - self-checking bench for x83_seq_ctrl
module tb_x83_seq_ctrl;

    localparam int WIDTH = 8;
`ifdef X83_FULL_PROD_EN
    localparam int OW = WIDTH + 7;
`else
    localparam int OW = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    data_out;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    x83_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer product reduced to the output width
    function automatic logic [31:0] model(input int x);
        longint p;
        p = longint'(x) * 83;
        return 32'(p % (longint'(1) << OW));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // One full transaction; with noise, in_valid stays high and data_in churns while busy
    task automatic do_op(input int x, input int stall, input bit noise);
        logic [31:0] exp;
        exp = model(x);
        in_valid = 1'b1;
        data_in  = WIDTH'(x);
        out_ready = 1'b0;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = noise;
        data_in  = noise ? WIDTH'($urandom) : '0;
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_in_ready", 32'(in_ready), 32'd0);
        check("lat_t0", 32'(out_valid), 32'd0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (noise) data_in = WIDTH'($urandom);
            check("lat_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("lat_t3_valid", 32'(out_valid), 32'd1);
        check("result", 32'(data_out), exp);
        for (int s = 0; s < stall; s++) begin
            if (noise) data_in = WIDTH'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(data_out), exp);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle("post_done");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_data", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle");
        check("idle_data", 32'(data_out), 32'd0);

        // Known products
        do_op(3, 0, 1'b0);
        check("const_3", 32'(data_out), 32'h0F9);
        do_op(255, 0, 1'b0);
`ifdef X83_FULL_PROD_EN
        check("const_255", 32'(data_out), 32'h52AD);
`else
        check("const_255", 32'(data_out), 32'hAD);
`endif
        do_op(100, 6, 1'b0);
        do_op(0, 0, 1'b0);
        check("const_0", 32'(data_out), 32'd0);

        // Operand churn during ACC/DONE, then a back-to-back second operand
        do_op(42, 2, 1'b1);
        do_op(200, 0, 1'b1);

        // Asynchronous reset in the middle of the sequence
        in_valid = 1'b1;
        data_in  = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset_data", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(1, 0, 1'b0);
        check("const_1", 32'(data_out), 32'h53);

        // Random operands, stalls and input noise
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
